// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Defining FETCH_ADEL_EN adds an address-error flag to every buffered fetch entry.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic {
    S_FETCH,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef FETCH_ADEL_EN
    logic        adel;
`endif
  } fetch_entry_t;

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, instr} entries; head is combinational.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack reads, buffers {pc, instr} for IF/ID.
// Optional FETCH_ADEL_EN: misaligned/out-of-range PCs push an address-error entry instead of reading.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        exc_adel_out
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if ((FIFO_DEPTH != 2 && FIFO_DEPTH != 4) || IM_WORDS < 1) begin : g_bad_config
    $error("fetch_unit: FIFO_DEPTH must be 2 or 4 and IM_WORDS must be positive");
  end

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          outstanding_q, outstanding_d;
  logic          room, acked, pc_bad, adel_ready, adel_push;
  logic          fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry, head;

`ifdef FETCH_ADEL_EN
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  logic adel_done_q, adel_done_d;

  assign pc_bad = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < RESET_PC) ||
                  ({1'b0, fetch_pc_q} >= PC_LIMIT);
  // One error entry per bad PC; the PC then parks until decode redirects.
  assign adel_ready  = pc_bad && room && !outstanding_q && !adel_done_q;
  assign adel_done_d = redirect ? 1'b0 : (adel_done_q || adel_push);

  always_ff @(posedge clk) begin
    if (rst) adel_done_q <= 1'b0;
    else     adel_done_q <= adel_done_d;
  end
`else
  assign pc_bad     = 1'b0;
  assign adel_ready = 1'b0;
`endif

  // A new read starts only when its data is guaranteed a FIFO slot.
  assign room      = (fifo_count < CW'(FIFO_DEPTH));
  assign imem_req  = !rst && (outstanding_q || (state_q == S_FETCH && room && !pc_bad));
  assign imem_addr = word_addr(fetch_pc_q);
  assign acked     = imem_req && imem_ack;
  assign fifo_pop  = valid_out && !stall && !redirect;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    outstanding_d = imem_req && !imem_ack;
    fifo_push     = 1'b0;
    adel_push     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          if (outstanding_d) begin
            pend_pc_d = redirect_pc;
            state_d   = S_DROP;
          end else begin
            fetch_pc_d = redirect_pc;
          end
        end else if (acked) begin
          fifo_push  = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (adel_ready) begin
          fifo_push = 1'b1;
          adel_push = 1'b1;
        end
      end
      S_DROP: begin
        // The stale read must finish before the address may change; its data is dropped.
        if (redirect) pend_pc_d = redirect_pc;
        if (acked) begin
          fetch_pc_d = redirect ? redirect_pc : pend_pc_q;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      fetch_pc_q    <= RESET_PC;
      pend_pc_q     <= RESET_PC;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_pc_q     <= pend_pc_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = fetch_pc_q;
    push_entry.instr = adel_push ? NOP_INSTR : imem_rdata;
`ifdef FETCH_ADEL_EN
    push_entry.adel  = adel_push;
`endif
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .count_o (fifo_count),
    .head_o  (head),
    .empty_o (fifo_empty)
  );

  assign valid_out = !fifo_empty;
  assign instr_out = valid_out ? head.instr : NOP_INSTR;
  assign pc_out    = valid_out ? head.pc : 32'h0;
`ifdef FETCH_ADEL_EN
  assign exc_adel_out = valid_out && head.adel;
`else
  assign exc_adel_out = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, redirect/stall corner sequences,
// and a randomized run checked against a program-order model of the fetched stream.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req, imem_ack, valid_out, exc_adel_out;
  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;

  int total = 0;
  int bad = 0;
  int cur_lat = 0;
  int wait_cnt = 0;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .exc_adel_out (exc_adel_out)
  );

  always #5 clk = ~clk;

  // Memory model: ack after cur_lat waiting cycles, data = address ^ 0xFFFF.
  assign imem_ack   = imem_req && (wait_cnt >= cur_lat);
  assign imem_rdata = imem_ack ? (imem_addr ^ 32'h0000_FFFF) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic r, input logic s, input logic q,
                              input logic [31:0] a, input logic v, input logic [31:0] p);
    vec_t t;
    t.rst = r; t.stl = s; t.exp_req = q; t.exp_addr = a; t.exp_valid = v; t.exp_pc = p;
    return t;
  endfunction

  function automatic logic [31:0] expInstr(input logic [31:0] pc);
    return pc ^ 32'h0000_FFFF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Advance one clock, drive this cycle's inputs, then settle to mid-cycle for sampling.
  task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    #4;
  endtask

  task automatic doReset(input int lat);
    cur_lat = lat;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkHead(input string name, input logic v, input logic [31:0] p);
    checkOutput({name, ".valid"}, 32'(valid_out), 32'(v));
    checkOutput({name, ".pc"}, pc_out, v ? p : 32'h0);
    checkOutput({name, ".instr"}, instr_out, v ? expInstr(p) : 32'h0);
  endtask

  task automatic checkReq(input string name, input logic q, input logic [31:0] a);
    checkOutput({name, ".req"}, 32'(imem_req), 32'(q));
    if (q) checkOutput({name, ".addr"}, imem_addr, a);
  endtask

  initial begin
    logic [31:0] exp_pc, prev_addr, rpc;
    logic        prev_hold, flush_prev, rd, st;
    int          pops;

    // Reset, zero-wait streaming, then stall with a full buffer and drain.
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h3000, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h3004, 1, 32'h3000));
    vecs.push_back(mk(0, 0, 1, 32'h3008, 1, 32'h3004));
    vecs.push_back(mk(0, 0, 1, 32'h300C, 1, 32'h3008));
    vecs.push_back(mk(1, 0, 0, 32'h0,    1, 32'h300C));
    vecs.push_back(mk(0, 1, 1, 32'h3000, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h3004, 1, 32'h3000));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3000));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3000));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3000));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 32'h3000));
    vecs.push_back(mk(0, 0, 1, 32'h3008, 1, 32'h3004));
    vecs.push_back(mk(0, 0, 1, 32'h300C, 1, 32'h3008));

    doReset(0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stl, 1'b0, 32'h0);
      checkReq($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
      checkHead($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // Redirect while a 3-cycle read is pending: stale read completes, its data is dropped.
    doReset(3);
    for (int t = 0; t <= 8; t++) begin
      applyStimulus(1'b0, 1'b0, t == 1, 32'h3100);
      if (t <= 3)      checkReq($sformatf("drop.t%0d", t), 1'b1, 32'h3000);
      else if (t == 4) checkReq("drop.t4", 1'b1, 32'h3100);
      checkHead($sformatf("drop.t%0d", t), t == 8, 32'h3100);
    end

    // Redirect coinciding with ack while stalled on one buffered entry.
    doReset(0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkReq("rdack.c0", 1'b1, 32'h3000);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3400);
    checkReq("rdack.c1", 1'b1, 32'h3004);
    checkHead("rdack.c1", 1'b1, 32'h3000);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkHead("rdack.c2", 1'b0, 32'h0);
    checkReq("rdack.c2", 1'b1, 32'h3400);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkHead("rdack.c3", 1'b1, 32'h3400);

    // Two redirects during one pending read: only the newest target is fetched.
    doReset(3);
    for (int t = 0; t <= 8; t++) begin
      applyStimulus(1'b0, 1'b0, t == 1 || t == 2, (t == 1) ? 32'h3200 : 32'h3300);
      if (t == 3) checkReq("dbl.t3", 1'b1, 32'h3000);
      if (t == 4) checkReq("dbl.t4", 1'b1, 32'h3300);
      checkHead($sformatf("dbl.t%0d", t), t == 8, 32'h3300);
    end

    // Redirect to a misaligned target.
    doReset(0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h3002);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_ADEL_EN
    checkOutput("adel.c1.req", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("adel.c2.valid", 32'(valid_out), 32'd1);
    checkOutput("adel.c2.pc", pc_out, 32'h3002);
    checkOutput("adel.c2.instr", instr_out, 32'h0);
    checkOutput("adel.c2.exc", 32'(exc_adel_out), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("adel.c3.req", 32'(imem_req), 32'd0);
`else
    checkReq("adel.c1", 1'b1, 32'h3000);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("adel.c2.valid", 32'(valid_out), 32'd1);
    checkOutput("adel.c2.pc", pc_out, 32'h3002);
    checkOutput("adel.c2.instr", instr_out, 32'h0000_CFFF);
    checkOutput("adel.c2.exc", 32'(exc_adel_out), 32'd0);
`endif

    // Randomized run: the popped stream must follow program order from the last redirect.
    doReset(0);
    exp_pc = RPC; pops = 0; prev_hold = 1'b0; prev_addr = 32'h0; flush_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rd  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 2) == 0);
      rpc = RPC + 32'(4 * $urandom_range(0, 1000));
      @(posedge clk);
      #1;
      if (wait_cnt == 0) cur_lat = $urandom_range(0, 3);
      rst = 1'b0; stall = st; redirect = rd; redirect_pc = rpc;
      #4;
      if (flush_prev) checkOutput("rnd.flush", 32'(valid_out), 32'd0);
      if (valid_out) begin
        checkOutput("rnd.pc", pc_out, exp_pc);
        checkOutput("rnd.instr", instr_out, expInstr(exp_pc));
        checkOutput("rnd.exc", 32'(exc_adel_out), 32'd0);
      end else begin
        checkOutput("rnd.bubble", pc_out | instr_out, 32'h0);
      end
      if (prev_hold) begin
        checkOutput("rnd.hold.req", 32'(imem_req), 32'd1);
        checkOutput("rnd.hold.addr", imem_addr, prev_addr);
      end
      if (rd) begin
        exp_pc = rpc;
      end else if (valid_out && !st) begin
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      prev_hold  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
      flush_prev = rd;
    end
    checkOutput("rnd.progress", 32'(pops > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned {pc, instr} pairs in a small FIFO.
- Presents the FIFO head to the IF/ID pipeline register, which captures it when not stalled.
- Honours the same stall signal as the IF/ID register.
- Accepts branch/jump redirects from the decode stage, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_3000, PC of the first fetch after reset.
- FIFO_DEPTH, 2, fetch-buffer entries; legal values 2 or 4.
- IM_WORDS, 4096, instruction-memory size in words; used only by the optional range check.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hazard unit holds decode; head is not consumed this cycle.
- redirect  in  1  decode resolved a taken branch/jump this cycle.
- redirect_pc  in  32  target PC, sampled when redirect=1.
- imem_req  out  1  read request, held until ack.
- imem_addr  out  32  word-aligned read address, stable while imem_req=1.
- imem_ack  in  1  read data valid this cycle; ignored when imem_req=0.
- imem_rdata  in  32  instruction word.
- instr_out  out  32  FIFO-head instruction; 0 (nop) when empty.
- pc_out  out  32  FIFO-head PC; 0 when empty.
- valid_out  out  1  FIFO non-empty.
- exc_adel_out  out  1  head entry carries an address-error flag (optional feature).

Behaviour:
Reset (synchronous):
- fetch_pc = RESET_PC; FIFO empty; state = S_FETCH; outputs instr/pc/valid/exc = 0.
- imem_req = 0 during the reset cycle.
- Reset mid-transaction abandons the outstanding request without waiting for ack; the memory model must tolerate this.

Outputs:
- Driven combinationally from FIFO-head registers; no added latency.
- Empty FIFO presents a bubble: instr_out = 0, pc_out = 0, valid_out = 0.

Pop:
- Occurs when valid_out=1, stall=0 and redirect=0.

Request:
- At most one outstanding request.
- New request asserted only when count + outstanding < FIFO_DEPTH.
- imem_addr = {fetch_pc[31:2], 2'b00}.
- On ack in S_FETCH with no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4 (32-bit wrap).
- Push and pop may occur in the same cycle.
- Full FIFO with stall: no request, contents held indefinitely.
- Zero-wait memory (ack in the request cycle) sustains one instruction per cycle.

States:
- S_FETCH: normal operation.
- S_DROP: a redirect arrived while a request was outstanding; keep imem_req/imem_addr stable until ack, discard the data, then set fetch_pc = pend_pc and return to S_FETCH.

Redirect:
- Takes priority over stall and pop; flushes the FIFO the same cycle, so valid_out=0 next cycle.
- No request outstanding, or ack in the same cycle: fetch_pc = redirect_pc, ack data discarded, stay in S_FETCH, next request issued the following cycle.
- Request outstanding without ack: pend_pc = redirect_pc, enter S_DROP.
- Redirect while already in S_DROP: pend_pc overwritten by the newest target.

Timing:
- Redirect-to-first-valid latency with zero-wait memory: 2 cycles.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- Defined:
  - A fetch_pc that is misaligned (pc[1:0] != 0) or outside [RESET_PC, RESET_PC + 4*IM_WORDS) issues no memory request.
  - Instead it pushes {pc, 32'h0, adel=1} when a slot is free.
  - fetch_pc then stops advancing until the next redirect.
  - exc_adel_out mirrors the head entry's flag.
- Undefined: no check; low address bits are masked on imem_addr; exc_adel_out tied 0; FIFO entries carry no flag bit.

Decomposition:
- Shared package fetch_pkg:
  - state encoding S_FETCH/S_DROP;
  - RESET_PC default constant;
  - NOP_INSTR = 32'h0;
  - fetch-entry struct {pc, instr, adel}.
- One natural sub-module, fetch_fifo: synchronous FIFO with push/pop/flush, count output, and a combinational head.
- FSM, PC and request logic stay in fetch_unit.

Test Plan:
1. Reset, then zero-wait memory returning addr^32'hFFFF: first valid_out cycle shows pc_out=0x3000; consecutive cycles show 0x3004, 0x3008; imem_req never high during rst.
2. Stall held 5 cycles with zero-wait memory: exactly FIFO_DEPTH entries accepted; imem_req low once full; head stays 0x3000 until stall drops, then 0x3000, 0x3004 drain in order.
3. Memory with 3-cycle ack latency, redirect to 0x3100 in the cycle after req: imem_addr stays 0x3000 until ack; that data never appears; next request addr = 0x3100; valid_out=0 throughout.
4. Redirect and ack in the same cycle with stall=1 and FIFO holding 1 entry: FIFO empty next cycle; next request addr = redirect_pc; ack data discarded.
5. Two redirects (0x3200 then 0x3300) during one pending request: only 0x3300 is fetched after ack.
6. FETCH_ADEL_EN defined, redirect to 0x3002: no imem_req; head shows pc_out=0x3002, instr_out=0, exc_adel_out=1. Repeat with macro undefined: imem_addr = 0x3000 and exc_adel_out = 0.
